pid_ctrl: RTL and testbench

Closed-loop motor-drive controller sitting directly downstream of the sensor-conditioning stage. It consumes the 13-bit signed current `error` and the `not_pedaling` flag. It forms proportional, decimated-integral and (optionally) derivative terms, and produces a saturated 12-bit unsigned `drv_mag` that feeds the motor commutation/PWM stage.

---
 rtl/pid_pkg.sv | 25 ++
 rtl/pid_sat.sv | 37 +++
 rtl/pid_ctrl.sv | 114 +++++++++++
 tb/tb_pid_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared widths, limits and helpers for the pid_ctrl motor-drive controller.
package pid_pkg;

    localparam int ERR_W   = 13;
    localparam int INTEG_W = 18;
    localparam int SUM_W   = 15;
    localparam int DRV_W   = 12;
    localparam int DSAT_W  = 9;

    localparam int DEC_W_SLOW = 20;
    localparam int DEC_W_FAST = 15;

    localparam logic [INTEG_W-1:0] INTEG_MAX = 18'h1FFFF;
    localparam logic [DRV_W-1:0]   DRV_MAX   = 12'hFFF;

    typedef enum logic {
        SAT_SIGNED   = 1'b0,
        SAT_UNSIGNED = 1'b1
    } sat_mode_e;

    function automatic int dec_width(input logic fast_sim);
        return fast_sim ? DEC_W_FAST : DEC_W_SLOW;
    endfunction

endpackage

// File: rtl/pid_sat.sv
// Signed-input saturator: clamps a two's-complement value into a narrower
// signed or unsigned range. Unsigned mode needs IN_W >= OUT_W + 2.
module pid_sat
    import pid_pkg::*;
#(
    parameter int        IN_W  = 15,
    parameter int        OUT_W = 12,
    parameter sat_mode_e MODE  = SAT_UNSIGNED
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout
);

    if (MODE == SAT_SIGNED) begin : g_signed
        // Value fits when every bit above the output sign bit copies the input sign.
        always_comb begin
            if (din[IN_W-1:OUT_W-1] == {(IN_W-OUT_W+1){din[IN_W-1]}}) begin
                dout = din[OUT_W-1:0];
            end else if (din[IN_W-1]) begin
                dout = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                dout = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    end else begin : g_unsigned
        always_comb begin
            if (din[IN_W-1]) begin
                dout = '0;
            end else if (|din[IN_W-2:OUT_W]) begin
                dout = '1;
            end else begin
                dout = din[OUT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pid_ctrl.sv
// P + decimated-I current-loop controller with a saturated 12-bit drive output.
// Define PID_DTERM_EN to build the derivative history and D term.
module pid_ctrl
    import pid_pkg::*;
#(
    parameter logic FAST_SIM = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ERR_W-1:0] error,
    input  logic             not_pedaling,
    output logic [DRV_W-1:0] drv_mag
);

    localparam int DEC_W = dec_width(FAST_SIM);

    logic [DEC_W-1:0]   dec_cnt_q, dec_cnt_d;
    logic               err_vld;
    logic [INTEG_W-1:0] integ_q, integ_d;
    logic [INTEG_W-1:0] integ_sum;
    logic [SUM_W-1:0]   p_term, i_term, d_term, pid;
    logic [DRV_W-1:0]   drv_mag_q, drv_mag_d;

    assign err_vld = &dec_cnt_q;

    always_comb begin
        dec_cnt_d = dec_cnt_q + DEC_W'(1);
    end

    always_comb begin
        integ_sum = integ_q + {{(INTEG_W-ERR_W){error[ERR_W-1]}}, error};
        integ_d   = integ_q;
        if (not_pedaling) begin
            integ_d = '0;
        end else if (err_vld) begin
            // A set top bit means underflow only for a negative error; otherwise it is overflow.
            if (error[ERR_W-1] && integ_sum[INTEG_W-1]) begin
                integ_d = '0;
            end else if (!integ_q[INTEG_W-1] && integ_sum[INTEG_W-1]) begin
                integ_d = INTEG_MAX;
            end else begin
                integ_d = integ_sum;
            end
        end
    end

    assign p_term = {{(SUM_W-ERR_W){error[ERR_W-1]}}, error};
    assign i_term = {2'b00, integ_q[16:4]};

`ifdef PID_DTERM_EN
    logic [ERR_W-1:0]  prev_q [3];
    logic [ERR_W-1:0]  prev_d [3];
    logic [ERR_W:0]    d_diff;
    logic [DSAT_W-1:0] d_sat;

    always_comb begin
        prev_d = prev_q;
        if (err_vld) begin
            prev_d[0] = error;
            prev_d[1] = prev_q[0];
            prev_d[2] = prev_q[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '{default: '0};
        end else begin
            prev_q <= prev_d;
        end
    end

    assign d_diff = {error[ERR_W-1], error} - {prev_q[2][ERR_W-1], prev_q[2]};

    pid_sat #(
        .IN_W  (ERR_W + 1),
        .OUT_W (DSAT_W),
        .MODE  (SAT_SIGNED)
    ) u_d_sat (
        .din  (d_diff),
        .dout (d_sat)
    );

    assign d_term = {{(SUM_W-DSAT_W-2){d_sat[DSAT_W-1]}}, d_sat, 2'b00};
`else
    assign d_term = '0;
`endif

    assign pid = p_term + i_term + d_term;

    pid_sat #(
        .IN_W  (SUM_W),
        .OUT_W (DRV_W),
        .MODE  (SAT_UNSIGNED)
    ) u_out_sat (
        .din  (pid),
        .dout (drv_mag_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt_q <= '0;
            integ_q   <= '0;
            drv_mag_q <= '0;
        end else begin
            dec_cnt_q <= dec_cnt_d;
            integ_q   <= integ_d;
            drv_mag_q <= drv_mag_d;
        end
    end

    assign drv_mag = drv_mag_q;

endmodule

// File: tb/tb_pid_ctrl.sv
// Directed self-checking bench for pid_ctrl (FAST_SIM build); expectations follow PID_DTERM_EN.
module tb_pid_ctrl;

    logic        clk          = 1'b0;
    logic        rst_n        = 1'b1;
    logic [12:0] error        = '0;
    logic        not_pedaling = 1'b0;
    logic [11:0] drv_mag;

    int checks   = 0;
    int failures = 0;

`ifdef PID_DTERM_EN
    localparam logic [11:0] EXP_STEP      = 12'h4FC;
    localparam logic [11:0] EXP_AFTER_VLD = 12'h50C;
`else
    localparam logic [11:0] EXP_STEP      = 12'h100;
    localparam logic [11:0] EXP_AFTER_VLD = 12'h110;
`endif

    pid_ctrl #(
        .FAST_SIM (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .error        (error),
        .not_pedaling (not_pedaling),
        .drv_mag      (drv_mag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Jump the decimator to all ones for exactly one rising edge, giving one err_vld.
    task automatic pulse();
        force dut.dec_cnt_q = 15'h7FFF;
        tick();
        force dut.dec_cnt_q = 15'h0000;
        release dut.dec_cnt_q;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (drv_mag !== 12'h000) begin
            failures++;
            $display("[TB] FAIL reset_drv: got=%h want=%h", drv_mag, 12'h000);
        end
        checks++;
        if (dut.integ_q !== 18'h00000) begin
            failures++;
            $display("[TB] FAIL reset_integ: got=%h want=%h", dut.integ_q, 18'h00000);
        end
        checks++;
        if (dut.dec_cnt_q !== 15'h0000) begin
            failures++;
            $display("[TB] FAIL reset_dec: got=%h want=%h", dut.dec_cnt_q, 15'h0000);
        end
    endtask

    task automatic test_step();
        error = 13'h0100;
        rst_n = 1'b1;
        tick();
        checks++;
        if (drv_mag !== EXP_STEP) begin
            failures++;
            $display("[TB] FAIL step_up: got=%h want=%h", drv_mag, EXP_STEP);
        end
        error = 13'h0000;
        tick();
        checks++;
        if (drv_mag !== 12'h000) begin
            failures++;
            $display("[TB] FAIL step_down: got=%h want=%h", drv_mag, 12'h000);
        end
    endtask

    task automatic test_negative();
        error = 13'h1E00;
        for (int k = 0; k < 3; k++) begin
            pulse();
            checks++;
            if (dut.integ_q !== 18'h00000) begin
                failures++;
                $display("[TB] FAIL neg_integ[%0d]: got=%h want=%h", k, dut.integ_q, 18'h00000);
            end
            tick();
            checks++;
            if (drv_mag !== 12'h000) begin
                failures++;
                $display("[TB] FAIL neg_drv[%0d]: got=%h want=%h", k, drv_mag, 12'h000);
            end
        end
    endtask

    task automatic test_integ_sat();
        int          m;
        logic [17:0] exp_integ;
        m = 0;
        error = 13'h07FF;
        for (int n = 1; n <= 66; n++) begin
            pulse();
            m = m + 2047;
            if (m >= 131072) m = 131071;
            exp_integ = m[17:0];
            checks++;
            if (dut.integ_q !== exp_integ) begin
                failures++;
                $display("[TB] FAIL sat_integ[%0d]: got=%h want=%h", n, dut.integ_q, exp_integ);
            end
            if (n == 64) begin
                checks++;
                if (dut.integ_q !== 18'd131008) begin
                    failures++;
                    $display("[TB] FAIL sat_integ64: got=%0d want=%0d", dut.integ_q, 131008);
                end
            end
            if (n >= 65) begin
                checks++;
                if (dut.integ_q !== 18'h1FFFF) begin
                    failures++;
                    $display("[TB] FAIL sat_integ_max[%0d]: got=%h want=%h", n, dut.integ_q, 18'h1FFFF);
                end
            end
            if (n >= 64) begin
                checks++;
                if (drv_mag !== 12'hFFF) begin
                    failures++;
                    $display("[TB] FAIL sat_drv[%0d]: got=%h want=%h", n, drv_mag, 12'hFFF);
                end
            end
        end
        tick();
        checks++;
        if (drv_mag !== 12'hFFF) begin
            failures++;
            $display("[TB] FAIL sat_drv_hold: got=%h want=%h", drv_mag, 12'hFFF);
        end
    endtask

    task automatic test_clear();
        error = 13'h0000;
        repeat (3) tick();
        checks++;
        if (drv_mag !== 12'hFFF) begin
            failures++;
            $display("[TB] FAIL clear_pre_drv: got=%h want=%h", drv_mag, 12'hFFF);
        end
        not_pedaling = 1'b1;
        pulse();
        checks++;
        if (dut.integ_q !== 18'h00000) begin
            failures++;
            $display("[TB] FAIL clear_integ: got=%h want=%h", dut.integ_q, 18'h00000);
        end
        checks++;
        if (drv_mag !== 12'hFFF) begin
            failures++;
            $display("[TB] FAIL clear_drv_lag: got=%h want=%h", drv_mag, 12'hFFF);
        end
        tick();
        checks++;
        if (drv_mag !== 12'h000) begin
            failures++;
            $display("[TB] FAIL clear_drv: got=%h want=%h", drv_mag, 12'h000);
        end
        pulse();
        checks++;
        if (dut.integ_q !== 18'h00000) begin
            failures++;
            $display("[TB] FAIL clear_integ_hold: got=%h want=%h", dut.integ_q, 18'h00000);
        end
        not_pedaling = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_run();
        int vld_seen;
        vld_seen = 0;
        error = 13'h0FFF;
        pulse();
        checks++;
        if (dut.integ_q !== 18'd4095) begin
            failures++;
            $display("[TB] FAIL mid_integ: got=%0d want=%0d", dut.integ_q, 4095);
        end
        tick();
        checks++;
        if (drv_mag !== 12'hFFF) begin
            failures++;
            $display("[TB] FAIL mid_drv: got=%h want=%h", drv_mag, 12'hFFF);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (drv_mag !== 12'h000) begin
            failures++;
            $display("[TB] FAIL async_drv: got=%h want=%h", drv_mag, 12'h000);
        end
        checks++;
        if (dut.integ_q !== 18'h00000) begin
            failures++;
            $display("[TB] FAIL async_integ: got=%h want=%h", dut.integ_q, 18'h00000);
        end
        @(negedge clk);
        tick();
        error = 13'h0100;
        rst_n = 1'b1;
        for (int i = 0; i < 32766; i++) begin
            tick();
            if (dut.err_vld) vld_seen++;
            if (i == 0) begin
                checks++;
                if (drv_mag !== EXP_STEP) begin
                    failures++;
                    $display("[TB] FAIL restart_step: got=%h want=%h", drv_mag, EXP_STEP);
                end
            end
        end
        checks++;
        if (vld_seen !== 0) begin
            failures++;
            $display("[TB] FAIL early_vld: got=%0d pulses want=%0d", vld_seen, 0);
        end
        tick();
        checks++;
        if (dut.err_vld !== 1'b1) begin
            failures++;
            $display("[TB] FAIL vld_32767: got=%b want=%b", dut.err_vld, 1'b1);
        end
        checks++;
        if (drv_mag !== EXP_STEP) begin
            failures++;
            $display("[TB] FAIL vld_drv: got=%h want=%h", drv_mag, EXP_STEP);
        end
        tick();
        checks++;
        if (dut.integ_q !== 18'd256) begin
            failures++;
            $display("[TB] FAIL first_integ: got=%0d want=%0d", dut.integ_q, 256);
        end
        checks++;
        if (dut.err_vld !== 1'b0) begin
            failures++;
            $display("[TB] FAIL vld_single: got=%b want=%b", dut.err_vld, 1'b0);
        end
        tick();
        checks++;
        if (drv_mag !== EXP_AFTER_VLD) begin
            failures++;
            $display("[TB] FAIL after_vld_drv: got=%h want=%h", drv_mag, EXP_AFTER_VLD);
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_negative();
        test_integ_sat();
        test_clear();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
